// File: rtl/i2c_cfg_fetch_pkg.sv
// Shared constants, FSM encoding and committed-config layout for i2c_cfg_fetch.
// CFG_CHKSUM_EN extends the scan to the checksum word at ADDR_CHKSUM.
package i2c_cfg_pkg;

  localparam int ADDR_W       = 3;
  localparam int DATA_W       = 16;
  localparam int WAIT_W       = 2;
  localparam int MCLK_SPEED_W = 16;
  localparam int MCLK_MODE_W  = 2;
  localparam int ROWS_DELAY_W = 16;
  localparam int IDLE_MODE_W  = 1;

  localparam logic [ADDR_W-1:0] ADDR_MCLK_SPEED = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MCLK_MODE  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_ROWS_DELAY = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_IDLE_MODE  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CHKSUM     = 3'd7;

`ifdef CFG_CHKSUM_EN
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_CHKSUM;
`else
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_IDLE_MODE;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CAPT,
    ST_CMP,
    ST_PEND
  } state_e;

  // Only the bits the consumer uses; comparing this struct ignores the rest.
  typedef struct packed {
    logic [MCLK_SPEED_W-1:0] mclk_speed;
    logic [MCLK_MODE_W-1:0]  mclk_mode;
    logic [ROWS_DELAY_W-1:0] rows_delay;
    logic [IDLE_MODE_W-1:0]  idle_mode;
  } cfg_t;

endpackage

// File: rtl/i2c_cfg_fetch_if.sv
// Parallel register read port between i2c_cfg_fetch (master) and I2C_SLAVE (slave).
interface i2c_cfg_fetch_if;
  import i2c_cfg_pkg::*;

  logic              RD_EN;
  logic [ADDR_W-1:0] ADD_OUT;
  logic [DATA_W-1:0] DAT_IN;

  modport master (output RD_EN, output ADD_OUT, input DAT_IN);
  modport slave  (input RD_EN, input ADD_OUT, output DAT_IN);

endinterface

// File: rtl/i2c_cfg_fetch_timer.sv
// Free-running poll divider: tick is high for one cycle every POLL_DIV cycles.
module cfg_poll_timer #(
  parameter int POLL_DIV = 1000
) (
  input  logic CLOCK,
  input  logic RESET,
  output logic tick
);

  localparam int CW = $clog2(POLL_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(POLL_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_cfg_fetch.sv
// Scans config regs 0..3 (plus 7 with CFG_CHKSUM_EN) into a shadow and commits changes on FRAME_SYNC.
// Each word costs RD_LAT+2 cycles; ticks outside IDLE are dropped and PEND freezes the shadow.
module i2c_cfg_fetch
  import i2c_cfg_pkg::*;
#(
  parameter int POLL_DIV = 1000,
  parameter int RD_LAT   = 1
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  i2c_cfg_fetch_if.master         rd,
  input  logic                    FRAME_SYNC,
  output logic [MCLK_SPEED_W-1:0] MCLK_SPEED,
  output logic [MCLK_MODE_W-1:0]  MCLK_MODE,
  output logic [ROWS_DELAY_W-1:0] ROWS_DELAY,
  output logic [IDLE_MODE_W-1:0]  IDLE_MODE,
  output logic                    CFG_VALID,
  output logic                    CFG_UPDATE,
  output logic                    CFG_ERR
);

  logic              tick;
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] add_q;
  logic [ADDR_W-1:0] addr_next;
  logic              rd_en_q;
  logic [WAIT_W-1:0] wait_q;
  cfg_t              shadow_q;
  cfg_t              cfg_q;
  logic              valid_q;
  logic              update_q;
`ifdef CFG_CHKSUM_EN
  logic [DATA_W-1:0] xor_q;
  logic [DATA_W-1:0] chk_q;
  logic              err_q;
`endif

  cfg_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .tick  (tick)
  );

`ifdef CFG_CHKSUM_EN
  assign addr_next = (addr_q == ADDR_IDLE_MODE) ? ADDR_CHKSUM : addr_q + ADDR_W'(1);
`else
  assign addr_next = addr_q + ADDR_W'(1);
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      add_q    <= '0;
      rd_en_q  <= 1'b0;
      wait_q   <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
`ifdef CFG_CHKSUM_EN
      xor_q    <= '0;
      chk_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      rd_en_q  <= 1'b0;
      update_q <= 1'b0;
`ifdef CFG_CHKSUM_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_REQ;
            rd_en_q <= 1'b1;
            add_q   <= addr_q;
          end
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
          wait_q  <= WAIT_W'(RD_LAT - 1);
        end
        ST_WAIT: begin
          if (wait_q == '0) begin
            state_q <= ST_CAPT;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_CAPT: begin
          case (addr_q)
            ADDR_MCLK_SPEED: shadow_q.mclk_speed <= rd.DAT_IN[MCLK_SPEED_W-1:0];
            ADDR_MCLK_MODE:  shadow_q.mclk_mode  <= rd.DAT_IN[MCLK_MODE_W-1:0];
            ADDR_ROWS_DELAY: shadow_q.rows_delay <= rd.DAT_IN[ROWS_DELAY_W-1:0];
            ADDR_IDLE_MODE:  shadow_q.idle_mode  <= rd.DAT_IN[IDLE_MODE_W-1:0];
            default: ;
          endcase
`ifdef CFG_CHKSUM_EN
          // Running XOR over the full data words, restarted at the first address.
          if (addr_q == ADDR_CHKSUM) begin
            chk_q <= rd.DAT_IN;
          end else if (addr_q == ADDR_MCLK_SPEED) begin
            xor_q <= rd.DAT_IN;
          end else begin
            xor_q <= xor_q ^ rd.DAT_IN;
          end
`endif
          if (addr_q == ADDR_LAST) begin
            addr_q  <= '0;
            state_q <= ST_CMP;
          end else begin
            addr_q  <= addr_next;
            add_q   <= addr_next;
            rd_en_q <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_CMP: begin
`ifdef CFG_CHKSUM_EN
          if (xor_q != chk_q) begin
            err_q    <= 1'b1;
            shadow_q <= '0;
            state_q  <= ST_IDLE;
          end else
`endif
          if (!valid_q || (shadow_q != cfg_q)) begin
            state_q <= ST_PEND;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PEND: begin
          if (FRAME_SYNC) begin
            cfg_q    <= shadow_q;
            update_q <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd.RD_EN    = rd_en_q;
  assign rd.ADD_OUT  = add_q;
  assign MCLK_SPEED  = cfg_q.mclk_speed;
  assign MCLK_MODE   = cfg_q.mclk_mode;
  assign ROWS_DELAY  = cfg_q.rows_delay;
  assign IDLE_MODE   = cfg_q.idle_mode;
  assign CFG_VALID   = valid_q;
  assign CFG_UPDATE  = update_q;
`ifdef CFG_CHKSUM_EN
  assign CFG_ERR     = err_q;
`else
  assign CFG_ERR     = 1'b0;
`endif

endmodule
